// File: rtl/dwr_pkg.sv
// rtl/dwr_pkg.sv - TAP state codes, instruction codes and chain-mode decode for the die wrapper chain
package dwr_pkg;

  localparam logic [3:0] TAP_TLR        = 4'b1111;
  localparam logic [3:0] TAP_CAPTURE_DR = 4'b0110;
  localparam logic [3:0] TAP_SHIFT_DR   = 4'b0010;
  localparam logic [3:0] TAP_UPDATE_DR  = 4'b0101;

  localparam logic [3:0] IR_EXTEST = 4'b0000;
  localparam logic [3:0] IR_INTEST = 4'b0010;
  localparam logic [3:0] IR_SAMPLE = 4'b0100;
  localparam logic [3:0] IR_CLAMP  = 4'b0110;
  localparam logic [3:0] IR_SAFE   = 4'b1000;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_EXTEST = 2'd1,
    MODE_INTEST = 2'd2,
    MODE_SAMPLE = 2'd3
  } chain_mode_t;

  // CLAMP, SAFE and every unassigned code route TDI through the bypass bit.
  function automatic chain_mode_t decode_mode(input logic [3:0] ir);
    case (ir)
      IR_EXTEST: return MODE_EXTEST;
      IR_INTEST: return MODE_INTEST;
      IR_SAMPLE: return MODE_SAMPLE;
      default:   return MODE_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/dwr_cell.sv
// rtl/dwr_cell.sv - one wrapper boundary cell: capture/shift stage plus update latch
module dwr_cell
  import dwr_pkg::*;
(
  input  logic TCK,
  input  logic TRST,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic capture_from_latch,
  input  logic par_in,
  input  logic scan_in,
  output logic scan_q,
  output logic upd_q
);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      scan_q <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      if (capture_en)
        scan_q <= capture_from_latch ? upd_q : par_in;
      else if (shift_en)
        scan_q <= scan_in;
      if (update_en)
        upd_q <= scan_q;
    end
  end

endmodule

// File: rtl/die_wrapper_chain.sv
// rtl/die_wrapper_chain.sv - die boundary wrapper chain with bypass bit and shift-length checking
module die_wrapper_chain
  import dwr_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter logic [N_OUT-1:0] SAFE_OUT = '0
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TDI,
  input  logic [3:0]       tap_state,
  input  logic [3:0]       IR,
  input  logic [N_IN-1:0]  pin_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] pin_out,
  output logic             wrapper_tdo,
  output logic             shift_err
);

  localparam int L  = N_IN + N_OUT;
  localparam int CW = $clog2(L + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

  chain_mode_t   mode;
  logic          chain;
  logic          capture_en;
  logic          shift_en;
  logic          update_req;
  logic          update_en;
  logic [CW-1:0] shift_cnt;
  logic          bypass_q;
  logic [L-1:0]  scan_q;
  logic [L-1:0]  upd_q;
  logic [L-1:0]  scan_src;

  assign mode       = decode_mode(IR);
  assign chain      = (mode != MODE_BYPASS);
  assign capture_en = chain && (tap_state == TAP_CAPTURE_DR);
  assign shift_en   = chain && (tap_state == TAP_SHIFT_DR);
  assign update_req = chain && (tap_state == TAP_UPDATE_DR);
  // A short or long scan leaves the latches alone; only an exact-length scan commits.
  assign update_en  = update_req && (shift_cnt == CNT_FULL);
  assign scan_src   = {TDI, scan_q[L-1:1]};

  for (genvar i = 0; i < L; i++) begin : g_cell
    logic par;
    logic from_latch;
    if (i < N_IN) begin : g_in
      assign par        = pin_in[i];
      assign from_latch = (mode == MODE_INTEST);
    end else begin : g_out
      assign par        = core_out[i-N_IN];
      assign from_latch = (mode == MODE_EXTEST);
    end
    dwr_cell u_cell (
      .TCK                (TCK),
      .TRST               (TRST),
      .capture_en         (capture_en),
      .shift_en           (shift_en),
      .update_en          (update_en),
      .capture_from_latch (from_latch),
      .par_in             (par),
      .scan_in            (scan_src[i]),
      .scan_q             (scan_q[i]),
      .upd_q              (upd_q[i])
    );
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)
      shift_cnt <= '0;
    else if (tap_state == TAP_CAPTURE_DR)
      shift_cnt <= '0;
    else if (shift_en && shift_cnt != CNT_SAT)
      shift_cnt <= shift_cnt + 1'b1;
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)
      shift_err <= 1'b0;
    else if (tap_state == TAP_TLR)
      shift_err <= 1'b0;
    else if (update_req && shift_cnt != CNT_FULL)
      shift_err <= 1'b1;
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)
      bypass_q <= 1'b0;
    else if (!chain) begin
      if (tap_state == TAP_CAPTURE_DR)
        bypass_q <= 1'b0;
      else if (tap_state == TAP_SHIFT_DR)
        bypass_q <= TDI;
    end
  end

  always_comb begin
    core_in = pin_in;
    if (IR == IR_INTEST)
      core_in = upd_q[N_IN-1:0];
  end

  always_comb begin
    pin_out = core_out;
    if (IR == IR_EXTEST || IR == IR_CLAMP)
      pin_out = upd_q[L-1:N_IN];
    else if (IR == IR_SAFE)
      pin_out = SAFE_OUT;
  end

  assign wrapper_tdo = chain ? scan_q[0] : bypass_q;

endmodule

// File: tb/tb_die_wrapper_chain.sv
// tb/tb_die_wrapper_chain.sv - scoreboard bench for die_wrapper_chain
module tb_die_wrapper_chain;

  localparam logic [3:0] S_TLR  = 4'b1111;
  localparam logic [3:0] S_CAP  = 4'b0110;
  localparam logic [3:0] S_SH   = 4'b0010;
  localparam logic [3:0] S_UPD  = 4'b0101;
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] I_EXT  = 4'b0000;
  localparam logic [3:0] I_INT  = 4'b0010;
  localparam logic [3:0] I_SMP  = 4'b0100;
  localparam logic [3:0] I_CLP  = 4'b0110;
  localparam logic [3:0] I_SAFE = 4'b1000;
  localparam logic [3:0] I_BYP  = 4'b1111;
  localparam logic [7:0] SAFE_V = 8'hC3;

  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       TDI = 1'b0;
  logic [3:0] tap_state = S_IDLE;
  logic [3:0] IR = I_SMP;
  logic [7:0] pin_in = 8'h00;
  logic [7:0] core_in;
  logic [7:0] core_out = 8'h00;
  logic [7:0] pin_out;
  logic       wrapper_tdo;
  logic       shift_err;

  int passed = 0;
  int total = 0;
  logic exp_q[$];

  die_wrapper_chain #(.N_IN(8), .N_OUT(8), .SAFE_OUT(SAFE_V)) dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state), .IR(IR),
    .pin_in(pin_in), .core_in(core_in), .core_out(core_out), .pin_out(pin_out),
    .wrapper_tdo(wrapper_tdo), .shift_err(shift_err)
  );

  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  // Capture, n shifts (TDO checked against queued expectations), then optional update.
  task automatic scan(input logic [3:0] ir, input logic [15:0] din, input int n, input bit upd);
    @(negedge TCK); IR = ir; tap_state = S_CAP; TDI = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge TCK); tap_state = S_SH; TDI = din[i % 16];
      if (exp_q.size() > 0) begin
        logic e;
        e = exp_q.pop_front();
        total++;
        if (wrapper_tdo !== e) $display("FAIL tdo_bit%0d ir=%b got %b exp %b", i, ir, wrapper_tdo, e);
        else passed++;
      end
    end
    @(negedge TCK); tap_state = upd ? S_UPD : S_IDLE;
    @(negedge TCK); tap_state = S_IDLE;
  endtask

  task automatic test_reset;
    TRST = 1'b1; IR = I_SMP; core_out = 8'h3C; pin_in = 8'hA5;
    repeat (2) @(negedge TCK);
    TRST = 1'b0;
    @(negedge TCK);
    total++; if (pin_out !== 8'h3C) $display("FAIL rst_pin_out got %h exp 3c", pin_out); else passed++;
    total++; if (shift_err !== 1'b0) $display("FAIL rst_err got %b exp 0", shift_err); else passed++;
    total++; if (wrapper_tdo !== 1'b0) $display("FAIL rst_tdo got %b exp 0", wrapper_tdo); else passed++;
    IR = I_INT; #1;
    total++; if (core_in !== 8'h00) $display("FAIL rst_core_in got %h exp 00", core_in); else passed++;
    IR = I_SMP;
  endtask

  task automatic test_sample;
    pin_in = 8'hA5; core_out = 8'h3C;
    push_bits({8'h3C, 8'hA5}, 16);
    scan(I_SMP, 16'h0000, 16, 1'b0);
    total++; if (exp_q.size() != 0) $display("FAIL sample_queue got %0d exp 0", exp_q.size()); else passed++;
    total++; if (core_in !== 8'hA5) $display("FAIL sample_core_in got %h exp a5", core_in); else passed++;
  endtask

  task automatic test_extest;
    push_bits({8'h00, 8'hA5}, 16);
    scan(I_EXT, {8'h81, 8'h00}, 16, 1'b1);
    total++; if (pin_out !== 8'h81) $display("FAIL extest_pin_out got %h exp 81", pin_out); else passed++;
    IR = I_CLP; #1;
    total++; if (pin_out !== 8'h81) $display("FAIL clamp_pin_out got %h exp 81", pin_out); else passed++;
  endtask

  task automatic test_intest;
    pin_in = 8'hFF;
    push_bits({8'h3C, 8'h00}, 16);
    scan(I_INT, {8'h00, 8'h5A}, 16, 1'b1);
    total++; if (core_in !== 8'h5A) $display("FAIL intest_core_in got %h exp 5a", core_in); else passed++;
    total++; if (pin_out !== 8'h3C) $display("FAIL intest_pin_out got %h exp 3c", pin_out); else passed++;
    total++; if (shift_err !== 1'b0) $display("FAIL intest_err got %b exp 0", shift_err); else passed++;
  endtask

  task automatic test_length_err;
    push_bits({8'h3C, 8'h5A}, 15);
    scan(I_INT, 16'hFFFF, 15, 1'b1);
    total++; if (core_in !== 8'h5A) $display("FAIL short_core_in got %h exp 5a", core_in); else passed++;
    total++; if (shift_err !== 1'b1) $display("FAIL short_err got %b exp 1", shift_err); else passed++;
    IR = I_EXT; #1;
    total++; if (pin_out !== 8'h00) $display("FAIL short_pin_out got %h exp 00", pin_out); else passed++;
    @(negedge TCK); tap_state = S_TLR;
    @(negedge TCK); tap_state = S_IDLE;
    total++; if (shift_err !== 1'b0) $display("FAIL tlr_err got %b exp 0", shift_err); else passed++;
    scan(I_INT, 16'hFFFF, 17, 1'b1);
    total++; if (shift_err !== 1'b1) $display("FAIL long_err got %b exp 1", shift_err); else passed++;
    total++; if (core_in !== 8'h5A) $display("FAIL long_core_in got %h exp 5a", core_in); else passed++;
    @(negedge TCK); tap_state = S_TLR;
    @(negedge TCK); tap_state = S_IDLE;
    total++; if (shift_err !== 1'b0) $display("FAIL tlr2_err got %b exp 0", shift_err); else passed++;
  endtask

  task automatic test_bypass_safe;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    scan(I_BYP, 16'h0005, 3, 1'b1);
    total++; if (wrapper_tdo !== 1'b1) $display("FAIL byp_tdo_last got %b exp 1", wrapper_tdo); else passed++;
    total++; if (pin_out !== 8'h3C) $display("FAIL byp_pin_out got %h exp 3c", pin_out); else passed++;
    total++; if (shift_err !== 1'b0) $display("FAIL byp_err got %b exp 0", shift_err); else passed++;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    scan(I_SAFE, 16'h0002, 3, 1'b1);
    total++; if (wrapper_tdo !== 1'b0) $display("FAIL safe_tdo_last got %b exp 0", wrapper_tdo); else passed++;
    total++; if (pin_out !== SAFE_V) $display("FAIL safe_pin_out got %h exp %h", pin_out, SAFE_V); else passed++;
    IR = I_INT; #1;
    total++; if (core_in !== 8'h5A) $display("FAIL byp_latch_kept got %h exp 5a", core_in); else passed++;
  endtask

  task automatic test_reset_midshift;
    scan(I_EXT, {8'hFF, 8'h00}, 16, 1'b1);
    total++; if (pin_out !== 8'hFF) $display("FAIL pre_rst_pin_out got %h exp ff", pin_out); else passed++;
    @(negedge TCK); tap_state = S_CAP; TDI = 1'b1;
    repeat (5) begin @(negedge TCK); tap_state = S_SH; end
    #2 TRST = 1'b1; #1;
    total++; if (pin_out !== 8'h00) $display("FAIL midrst_pin_out got %h exp 00", pin_out); else passed++;
    total++; if (wrapper_tdo !== 1'b0) $display("FAIL midrst_tdo got %b exp 0", wrapper_tdo); else passed++;
    @(negedge TCK); tap_state = S_IDLE;
    @(negedge TCK); TRST = 1'b0;
    @(negedge TCK); tap_state = S_UPD;
    @(negedge TCK); tap_state = S_IDLE;
    total++; if (pin_out !== 8'h00) $display("FAIL post_rst_update got %h exp 00", pin_out); else passed++;
    total++; if (shift_err !== 1'b1) $display("FAIL post_rst_err got %b exp 1", shift_err); else passed++;
    IR = I_SMP; #1;
    total++; if (pin_out !== core_out) $display("FAIL post_rst_sample got %h exp %h", pin_out, core_out); else passed++;
  endtask

  initial begin
    test_reset;
    test_sample;
    test_extest;
    test_intest;
    test_length_err;
    test_bypass_safe;
    test_reset_midshift;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/die_wrapper_chain.md
DIE_WRAPPER_CHAIN -- requirements
Module: die_wrapper_chain

Interface
REQ-001 Parameter N_IN, default 8, count of die input wrapper cells (pin to core); SHALL be >= 1.
REQ-002 Parameter N_OUT, default 8, count of die output wrapper cells (core to pin); SHALL be >= 1.
REQ-003 Parameter SAFE_OUT, default all-zero [N_OUT-1:0], pin_out value driven in SAFE mode.
REQ-004 TCK  input  1  sole clock; all state SHALL update on posedge TCK.
REQ-005 TRST  input  1  reset, asynchronous, active-high.
REQ-006 TDI  input  1  serial test data in.
REQ-007 tap_state  input  4  TAP state (TLR=1111, CAPTURE_DR=0110, SHIFT_DR=0010, UPDATE_DR=0101).
REQ-008 IR  input  4  active instruction (EXTEST=0000, INTEST=0010, SAMPLE=0100, CLAMP=0110, SAFE=1000; any other code = BYPASS).
REQ-009 pin_in  input  N_IN  die input pins.
REQ-010 core_in  output  N_IN  to core logic.
REQ-011 core_out  input  N_OUT  from core logic.
REQ-012 pin_out  output  N_OUT  to die output pins.
REQ-013 wrapper_tdo  output  1  serial test data out.
REQ-014 shift_err  output  1  sticky shift-length error flag.

Function
REQ-015 Chain length L = N_IN+N_OUT; shift bits [N_IN-1:0] are input cells, [L-1:N_IN] output cells; bit 0 nearest TDO.
REQ-016 Chain modes = EXTEST, INTEST, SAMPLE; all other IR codes select the 1-bit bypass register.
REQ-017 CAPTURE_DR, chain mode: input cells load pin_in (EXTEST, SAMPLE) or their update latch (INTEST); output cells load core_out (INTEST, SAMPLE) or their update latch (EXTEST).
REQ-018 CAPTURE_DR, non-chain mode: bypass register loads 0.
REQ-019 SHIFT_DR: chain mode shifts right one bit per TCK with TDI into bit L-1; non-chain mode bypass <= TDI.
REQ-020 Shift counter SHALL clear on CAPTURE_DR, increment per SHIFT_DR cycle in chain mode, saturate at L+1.
REQ-021 UPDATE_DR, chain mode, count == L: update latches <= shift register (SAMPLE acts as PRELOAD).
REQ-022 UPDATE_DR, chain mode, count != L: update latches SHALL hold and shift_err SHALL set.
REQ-023 shift_err SHALL clear only on TRST or tap_state == TLR.
REQ-024 core_in = input-cell update latch when IR == INTEST, else pin_in.
REQ-025 pin_out = output-cell update latch when IR is EXTEST or CLAMP; SAFE_OUT when SAFE; else core_out.
REQ-026 wrapper_tdo = shift[0] in chain mode, bypass register otherwise; combinational from state and IR.
REQ-027 IR change mid-shift SHALL take effect next TCK; shift contents SHALL be retained.
REQ-028 Non-chain modes SHALL never modify shift register or update latches.

Reset
REQ-029 TRST high SHALL clear shift register, update latches, bypass register, shift counter and shift_err to 0, independent of TCK.
REQ-030 Reset asserted mid-shift SHALL abort the operation; no partial update SHALL occur.

Structure
REQ-031 TAP-state codes, IR codes and the chain-mode decode belong in shared package dwr_pkg.
REQ-032 One sub-module is natural: dwr_cell (capture/shift stage plus update latch, capture-source select), instantiated L times.

Verification
REQ-033 Reset: TRST pulse mid-shift -> all state 0, shift_err=0, pin_out=core_out under IR=SAMPLE.
REQ-034 SAMPLE: pin_in=0xA5, core_out=0x3C, capture, shift 16 -> TDO sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 (bit0 first).
REQ-035 EXTEST preload: shift 0x81 into output cells over 16 shifts, UPDATE_DR -> pin_out=0x81; switch IR to CLAMP -> pin_out stays 0x81.
REQ-036 INTEST: shift 0x5A into input cells, update -> core_in=0x5A while pin_in=0xFF.
REQ-037 Length error: 15 shifts then UPDATE_DR -> latches unchanged, shift_err=1; TLR -> shift_err=0.
REQ-038 BYPASS (IR=1111) and SAFE: TDI sequence 1,0,1 -> TDO delayed one TCK; SAFE -> pin_out=SAFE_OUT.
